// File: rtl/n64_controller_rx_pkg.sv
// rtl/n64_controller_rx_pkg.sv - shared Joybus constants, FSM states and CRC helpers
package n64_controller_rx_pkg;

    localparam int SAMPLES_PER_LEVEL_DEF = 2;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [7:0] CRC_POLY = 8'h85;

    localparam logic [8:0] LEN_SHORT = 9'd8;
    localparam logic [8:0] LEN_READ  = 9'd24;
    localparam logic [8:0] LEN_WRITE = 9'd280;

    localparam logic [8:0] ADDR_LAST_BIT = 9'd24;
    localparam logic [8:0] DATA_FIRST_BIT = 9'd25;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_WAIT_FALL,
        ST_MEASURE_LOW,
        ST_MEASURE_HIGH,
        ST_WAIT_STOP,
        ST_HANDOFF
    } rx_state_t;

    function automatic logic [7:0] crc_step(input logic [7:0] acc, input logic b);
        return {acc[6:0], b} ^ (acc[7] ? CRC_POLY : 8'h00);
    endfunction

    // Total data bits (excluding stop) the console sends for a given command.
    function automatic logic [8:0] frame_len(input logic [7:0] c);
        case (c)
            CMD_READ:  return LEN_READ;
            CMD_WRITE: return LEN_WRITE;
            default:   return LEN_SHORT;
        endcase
    endfunction

endpackage

// File: rtl/n64_controller_rx_if.sv
// rtl/n64_controller_rx_if.sv - Joybus line, handoff and decoded-field bundle
interface n64_controller_rx_if;
    logic        data_rx;
    logic        rx_handoff;
    logic        cur_operation;
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  crc;
    logic        frame_error;

    modport master (
        output data_rx, rx_handoff,
        input  cur_operation, cmd, addr, crc, frame_error
    );

    modport slave (
        input  data_rx, rx_handoff,
        output cur_operation, cmd, addr, crc, frame_error
    );
endinterface

// File: rtl/joybus_pulse_decoder.sv
// rtl/joybus_pulse_decoder.sv - line synchronizer, edge detect and pulse-width counters
module joybus_pulse_decoder #(
    parameter int BIT_ONE_MAX_LOW = 4,
    parameter int MAX_LOW         = 16,
    parameter int HIGH_TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_fall,
    output logic o_rise,
    output logic o_bit,
    output logic o_low_err,
    output logic o_high_err,
    output logic o_idle_ok
);

    logic       r_meta;
    logic       r_s;
    logic       r_s_prev;
    logic [7:0] r_low_cnt;
    logic [7:0] r_high_cnt;

    // Synchronizer flops reset to the idle-high line level so reset release
    // never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta     <= 1'b1;
            r_s        <= 1'b1;
            r_s_prev   <= 1'b1;
            r_low_cnt  <= 8'd0;
            r_high_cnt <= 8'd0;
        end else begin
            r_meta   <= i_rx;
            r_s      <= r_meta;
            r_s_prev <= r_s;
            if (o_fall)
                r_low_cnt <= 8'd1;
            else if (!r_s && r_low_cnt != 8'hFF)
                r_low_cnt <= r_low_cnt + 8'd1;
            if (o_rise)
                r_high_cnt <= 8'd1;
            else if (r_s && r_high_cnt != 8'hFF)
                r_high_cnt <= r_high_cnt + 8'd1;
        end
    end

    assign o_fall     = r_s_prev & ~r_s;
    assign o_rise     = ~r_s_prev & r_s;
    assign o_bit      = (r_low_cnt <= 8'(BIT_ONE_MAX_LOW));
    assign o_low_err  = ~r_s & (r_low_cnt > 8'(MAX_LOW));
    assign o_high_err = r_s & (r_high_cnt > 8'(HIGH_TIMEOUT));
    assign o_idle_ok  = r_s & (r_high_cnt >= 8'(HIGH_TIMEOUT));

endmodule

// File: rtl/n64_controller_rx.sv
// rtl/n64_controller_rx.sv - Joybus receive FSM: command/address capture, write CRC, TX handoff
module n64_controller_rx
    import n64_controller_rx_pkg::*;
#(
    parameter int SAMPLES_PER_LEVEL = SAMPLES_PER_LEVEL_DEF,
    parameter int BIT_ONE_MAX_LOW   = 2 * SAMPLES_PER_LEVEL,
    parameter int MAX_LOW           = 8 * SAMPLES_PER_LEVEL,
    parameter int HIGH_TIMEOUT      = 8 * SAMPLES_PER_LEVEL
) (
    input  logic                sample_clk,
    input  logic                reset,
    n64_controller_rx_if.slave  bus
);

    logic w_fall;
    logic w_rise;
    logic w_bit;
    logic w_low_err;
    logic w_high_err;
    logic w_idle_ok;

    joybus_pulse_decoder #(
        .BIT_ONE_MAX_LOW (BIT_ONE_MAX_LOW),
        .MAX_LOW         (MAX_LOW),
        .HIGH_TIMEOUT    (HIGH_TIMEOUT)
    ) u_decoder (
        .clk        (sample_clk),
        .rst        (reset),
        .i_rx       (bus.data_rx),
        .o_fall     (w_fall),
        .o_rise     (w_rise),
        .o_bit      (w_bit),
        .o_low_err  (w_low_err),
        .o_high_err (w_high_err),
        .o_idle_ok  (w_idle_ok)
    );

    rx_state_t   r_state;
    logic [8:0]  r_bit_cnt;
    logic [8:0]  r_exp_len;
    logic [14:0] r_shift;
    logic [7:0]  r_crc_acc;
    logic        r_stop_low;
    logic        r_handoff_cap;
    logic        r_cur_op;
    logic [7:0]  r_cmd;
    logic [15:0] r_addr;
    logic [7:0]  r_crc;
    logic        r_frame_error;

    logic [8:0]  w_bit_cnt_nx;
    logic [7:0]  w_byte;

    assign w_bit_cnt_nx = r_bit_cnt + 9'd1;
    assign w_byte       = {r_shift[6:0], w_bit};

    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_ARM;
            r_bit_cnt     <= 9'd0;
            r_exp_len     <= LEN_SHORT;
            r_shift       <= 15'd0;
            r_crc_acc     <= 8'd0;
            r_stop_low    <= 1'b0;
            r_handoff_cap <= 1'b0;
            r_cur_op      <= 1'b0;
            r_cmd         <= 8'd0;
            r_addr        <= 16'd0;
            r_crc         <= 8'd0;
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    if (w_idle_ok) begin
                        r_state   <= ST_WAIT_FALL;
                        r_bit_cnt <= 9'd0;
                        r_crc_acc <= 8'd0;
                        r_exp_len <= LEN_SHORT;
                    end
                end
                ST_WAIT_FALL: begin
                    if (w_fall)
                        r_state <= ST_MEASURE_LOW;
                end
                ST_MEASURE_LOW: begin
                    if (w_low_err) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_ARM;
                    end else if (w_rise) begin
                        r_bit_cnt <= w_bit_cnt_nx;
                        r_shift   <= {r_shift[13:0], w_bit};
                        if (w_bit_cnt_nx == LEN_SHORT) begin
                            r_cmd     <= w_byte;
                            r_exp_len <= frame_len(w_byte);
                        end
                        if (w_bit_cnt_nx == ADDR_LAST_BIT)
                            r_addr <= {r_shift, w_bit};
                        if (r_cmd == CMD_WRITE && w_bit_cnt_nx >= DATA_FIRST_BIT)
                            r_crc_acc <= crc_step(r_crc_acc, w_bit);
                        r_state <= ST_MEASURE_HIGH;
                    end
                end
                ST_MEASURE_HIGH: begin
                    // A stop fall landing on the same cycle is still recorded.
                    if (r_bit_cnt == r_exp_len) begin
                        r_stop_low <= w_fall;
                        r_state    <= ST_WAIT_STOP;
                    end else if (w_high_err) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_ARM;
                    end else if (w_fall) begin
                        r_state <= ST_MEASURE_LOW;
                    end
                end
                ST_WAIT_STOP: begin
                    if (!r_stop_low) begin
                        if (w_high_err) begin
                            r_frame_error <= 1'b1;
                            r_state       <= ST_ARM;
                        end else if (w_fall) begin
                            r_stop_low <= 1'b1;
                        end
                    end else if (w_low_err) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_ARM;
                    end else if (w_rise) begin
                        r_cur_op      <= 1'b1;
                        r_crc         <= (r_cmd == CMD_WRITE) ? r_crc_acc : 8'd0;
                        r_handoff_cap <= bus.rx_handoff;
                        r_state       <= ST_HANDOFF;
                    end
                end
                ST_HANDOFF: begin
                    if (bus.rx_handoff != r_handoff_cap) begin
                        r_cur_op <= 1'b0;
                        r_state  <= ST_ARM;
                    end
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

    assign bus.cur_operation = r_cur_op;
    assign bus.cmd           = r_cmd;
    assign bus.addr          = r_addr;
    assign bus.crc           = r_crc;
    assign bus.frame_error   = r_frame_error;

endmodule

// File: tb/tb_n64_controller_rx.sv
// tb/tb_n64_controller_rx.sv - scoreboard bench for the Joybus receive front end
module tb_n64_controller_rx;

    logic clk = 1'b0;
    logic rst;

    n64_controller_rx_if bus();

    n64_controller_rx dut (
        .sample_clk (clk),
        .reset      (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  crc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_cur = 1'b0;
    logic prev_fe  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [15:0] a, input logic [7:0] r);
        exp_t e;
        e.is_err = 1'b0; e.cmd = c; e.addr = a; e.crc = r;
        exp_q.push_back(e);
    endtask

    task automatic push_error();
        exp_t e;
        e.is_err = 1'b1; e.cmd = 8'h00; e.addr = 16'h0000; e.crc = 8'h00;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.cur_operation && !prev_cur) begin
                check("handoff_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("handoff_kind", 32'(e.is_err), 0);
                    check("cmd", bus.cmd, e.cmd);
                    check("addr", bus.addr, e.addr);
                    check("crc", bus.crc, e.crc);
                end
            end
            if (bus.frame_error) begin
                check("error_expected", 32'(exp_q.size() != 0), 1);
                check("error_width", prev_fe, 0);
                check("error_curop", bus.cur_operation, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("error_kind", 32'(e.is_err), 1);
                end
            end
        end
        prev_cur = bus.cur_operation;
        prev_fe  = bus.frame_error;
    end

    task automatic level(input logic v, input int n);
        bus.data_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin level(1'b0, 2); level(1'b1, 6); end
        else   begin level(1'b0, 6); level(1'b1, 2); end
    endtask

    // cut > 0 stops partway: cut-1 full bits, then leaves the line low mid-bit.
    task automatic send_frame(input logic [7:0] c, input logic [15:0] a, input int one_idx, input int cut);
        int   len;
        logic b;
        len = (c == 8'h02) ? 24 : (c == 8'h03) ? 280 : 8;
        for (int i = 0; i < len; i++) begin
            if (cut > 0 && i == cut - 1) begin
                level(1'b0, 3);
                return;
            end
            if (i < 8)       b = c[7 - i];
            else if (i < 24) b = a[23 - i];
            else             b = ((i - 24) == one_idx);
            send_bit(b);
        end
        level(1'b0, 2);
        bus.data_rx = 1'b1;
    endtask

    task automatic wait_handoff(input int exp_lat);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.cur_operation) seen = 1'b1;
        end
        check("handoff_seen", 32'(seen), 1);
        if (seen && exp_lat > 0) check("handoff_latency", n, exp_lat);
        if (seen) begin
            repeat (3) @(negedge clk);
            check("handoff_hold", bus.cur_operation, 1);
            bus.rx_handoff = ~bus.rx_handoff;
            @(negedge clk);
            check("handoff_release", bus.cur_operation, 0);
        end
        level(1'b1, 20);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cur_operation"}, bus.cur_operation, 0);
        check({tag, "_cmd"}, bus.cmd, 0);
        check({tag, "_addr"}, bus.addr, 0);
        check({tag, "_crc"}, bus.crc, 0);
        check({tag, "_frame_error"}, bus.frame_error, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.data_rx = 1'b1;
        bus.rx_handoff = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        level(1'b1, 30);

        push_frame(8'h01, 16'h0000, 8'h00);
        send_frame(8'h01, 16'h0000, -1, 0);
        wait_handoff(3);

        push_frame(8'h00, 16'h0000, 8'h00);
        send_frame(8'h00, 16'h0000, -1, 0);
        wait_handoff(0);

        push_frame(8'h03, 16'h8001, 8'h01);
        send_frame(8'h03, 16'h8001, 255, 0);
        wait_handoff(0);

        push_frame(8'h03, 16'h8001, 8'h85);
        send_frame(8'h03, 16'h8001, 247, 0);
        wait_handoff(0);

        send_frame(8'h03, 16'hABCD, 3, 150);
        rst = 1'b1;
        #1;
        check_outputs_zero("midframe_reset");
        bus.data_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        level(1'b1, 30);

        push_frame(8'hFF, 16'h0000, 8'h00);
        send_frame(8'hFF, 16'h0000, -1, 0);
        wait_handoff(0);

        push_frame(8'h02, 16'h1234, 8'h00);
        send_frame(8'h02, 16'h1234, -1, 0);
        wait_handoff(0);

        push_error();
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        level(1'b0, 20);
        level(1'b1, 30);
        push_frame(8'h01, 16'h1234, 8'h00);
        send_frame(8'h01, 16'h0000, -1, 0);
        wait_handoff(0);

        push_error();
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        level(1'b0, 6);
        level(1'b1, 30);
        push_frame(8'h01, 16'h1234, 8'h00);
        send_frame(8'h01, 16'h0000, -1, 0);
        wait_handoff(0);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/n64_controller_rx.md
Name: n64_controller_rx

Overview:
Joybus receive front end for the emulated N64 controller. It sits directly upstream of the controller transmit stage. It oversamples the console's data line and decodes pulse-width-encoded bits into a command byte, plus an address and write payload for command 0x03. It computes the un-flushed write-data CRC remainder, then hands the line to the transmit stage via a level/toggle handshake.

Parameters:
SAMPLES_PER_LEVEL, 2, sample_clk cycles per Joybus level (1 us); must equal the TX stage's level width.
BIT_ONE_MAX_LOW, 2*SAMPLES_PER_LEVEL, a low pulse of at most this many cycles decodes as '1'; longer decodes as '0'.
MAX_LOW, 8*SAMPLES_PER_LEVEL, a low pulse longer than this is a framing error.
HIGH_TIMEOUT, 8*SAMPLES_PER_LEVEL, a mid-frame high period longer than this aborts the frame.

Ports:
sample_clk  input  1  sampling clock; all logic on posedge
reset  input  1  asynchronous, active-high reset
data_rx  input  1  raw Joybus line (open-drain, idle high)
rx_handoff  input  1  toggled by the TX stage when its response is complete
cur_operation  output  1  0 = receiving, 1 = TX stage owns the line
cmd  output  8  received command byte
addr  output  16  address bytes for commands 0x02 and 0x03
crc  output  8  CRC remainder over the 256 write-data bits (not flushed)
frame_error  output  1  one-cycle pulse on abort

Behaviour:
- Reset values: cur_operation=0, cmd=0, addr=0, crc=0, frame_error=0; internal state=ARM, counters=0. A reset mid-frame or mid-handoff discards everything.
- data_rx passes through a 2-flop synchronizer. All edge detection uses the synchronized value s versus its previous-cycle copy.
- States: ARM, WAIT_FALL, MEASURE_LOW, MEASURE_HIGH, WAIT_STOP, HANDOFF.
- ARM: s must stay high for HIGH_TIMEOUT consecutive cycles, then go to WAIT_FALL with bit_cnt=0 and crc_acc=0. Any low restarts the count.
- WAIT_FALL: on falling edge -> MEASURE_LOW with low_cnt=1.
- MEASURE_LOW: low_cnt increments, saturating at 8 bits.
  - If low_cnt > MAX_LOW -> frame_error pulse, go to ARM.
  - On rising edge, decode bit = (low_cnt <= BIT_ONE_MAX_LOW), shift it in MSB-first, increment bit_cnt (9 bits), then go to MEASURE_HIGH with high_cnt=1.
- MEASURE_HIGH:
  - If bit_cnt == expected_len -> WAIT_STOP.
  - Otherwise, on falling edge -> MEASURE_LOW.
  - If high_cnt > HIGH_TIMEOUT -> frame_error, go to ARM.
- expected_len is 8 until bit 8 is decoded. It is then set from cmd: 0x02 -> 24, 0x03 -> 280, all others (0x00, 0x01, 0xFF, unknown) -> 8.
- Field capture:
  - bits 1..8 -> cmd, latched when bit 8 is decoded.
  - bits 9..24 -> addr.
  - bits 25..280 (cmd 0x03 only) -> crc_acc update per bit: fb=crc_acc[7]; crc_acc={crc_acc[6:0],bit} ^ (fb ? 8'h85 : 8'h00).
- Payload bytes are not stored; only the CRC is retained.
- WAIT_STOP: the stop bit is a falling edge followed by a rising edge. The low duration is checked against MAX_LOW; no polarity decode is done. The high-timeout also applies while waiting for the stop falling edge.
- Stop-bit rising edge on cycle k: on cycle k+1, cur_operation=1, crc=crc_acc (0 for commands other than 0x03), and cmd/addr are stable. The current rx_handoff value is captured, then go to HANDOFF.
- HANDOFF: data_rx is ignored. When rx_handoff differs from the captured value, cur_operation=0 on the next cycle, then go to ARM. cmd, addr and crc hold until the next frame's bit 8/24/280 respectively.
- Unknown commands are handed off like any other; the TX stage toggles rx_handoff back immediately.
- frame_error pulses only from MEASURE_LOW, MEASURE_HIGH or WAIT_STOP; outputs keep their previous frame's values.

Decomposition:
- Shared joybus package holds: command codes (CMD_INFO=8'h00, CMD_STATUS=8'h01, CMD_READ=8'h02, CMD_WRITE=8'h03, CMD_RESET=8'hFF), CRC polynomial 8'h85, frame lengths (8/24/280), and the SAMPLES_PER_LEVEL default shared with the TX stage.
- One natural sub-module: joybus_pulse_decoder, containing the synchronizer, edge detect, low/high counters and bit/error strobes. The parent holds the FSM, bit counter, field capture and CRC.

Test Plan:
- Command 0x01 (pulses of 6 low/2 high per '0', 2 low/6 high per '1') plus stop bit -> cur_operation=1 two cycles after the stop rising edge; cmd=0x01, crc=0x00.
- After that handoff, toggle rx_handoff -> cur_operation=0 the following cycle; a new 0x00 frame sent after at least 16 high cycles decodes as cmd=0x00.
- Command 0x03, addr 0x8001, 256 data bits all zero except data bit index 255 (last) = 1 -> addr=0x8001, crc=0x01. With only data bit index 247 (9th from last) = 1 -> crc=0x85.
- Command 0x02, addr 0x1234 -> handoff after exactly 24 bits plus stop, addr=0x1234; no extra bits are consumed.
- A 20-cycle low pulse mid-byte, or 20 high cycles after bit 5 -> frame_error one-cycle pulse, cur_operation stays 0, and the receiver re-arms and decodes the next clean 0x01 frame.
- Assert reset during bit 150 of a 0x03 frame, release, then send 0xFF -> all outputs return to 0 immediately; the next frame decodes cmd=0xFF with crc=0x00.
